// File: rtl/csi_yuv_pkg.sv
// Shared constants and small helpers for the CSI RX RGB -> YUV422 output path.
// Coefficients are BT.601-style 8.8 fixed point; the pixel datapath scales by 2^PIXEL_DEPTH.
package csi_yuv_pkg;

    localparam logic signed [8:0] COEF_Y_R = 9'sd77;
    localparam logic signed [8:0] COEF_Y_G = 9'sd150;
    localparam logic signed [8:0] COEF_Y_B = 9'sd29;
    localparam logic signed [8:0] COEF_U_R = -9'sd43;
    localparam logic signed [8:0] COEF_U_G = -9'sd84;
    localparam logic signed [8:0] COEF_U_B = 9'sd127;
    localparam logic signed [8:0] COEF_V_R = 9'sd127;
    localparam logic signed [8:0] COEF_V_G = -9'sd106;
    localparam logic signed [8:0] COEF_V_B = -9'sd21;

    localparam logic [1:0] YUV_MODE_YUYV = 2'd0;
    localparam logic [1:0] YUV_MODE_UYVY = 2'd1;
    localparam logic [1:0] YUV_MODE_YVYU = 2'd2;
    localparam logic [1:0] YUV_MODE_VYUY = 2'd3;

    localparam logic [8:0] CHROMA_OFFSET = 9'd128;
    localparam logic [7:0] CLAMP_MIN     = 8'd0;
    localparam logic [7:0] CLAMP_MAX     = 8'd255;

    function automatic logic [7:0] chroma_avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum_s[8:1];
    endfunction

    function automatic logic [31:0] pack_pair(input logic [1:0] mode,
                                              input logic [7:0] y0, input logic [7:0] y1,
                                              input logic [7:0] u,  input logic [7:0] v);
        logic [31:0] word_s;
        case (mode)
            YUV_MODE_YUYV: word_s = {y0, u, y1, v};
            YUV_MODE_UYVY: word_s = {u, y0, v, y1};
            YUV_MODE_YVYU: word_s = {y0, v, y1, u};
            YUV_MODE_VYUY: word_s = {v, y0, u, y1};
            default:       word_s = {y0, u, y1, v};
        endcase
        return word_s;
    endfunction

endpackage

// File: rtl/rgb_to_yuv_pixel.sv
// One-pixel colour-space datapath: input register, weighted sums, shift/offset/clamp.
// Stage loads are driven by the parent's valid pipeline so data holds across bubbles.
module rgb_to_yuv_pixel
    import csi_yuv_pkg::*;
#(
    parameter int PIXEL_DEPTH = 12
)
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [3*PIXEL_DEPTH-1:0] rgb,
    input  logic                     load_s1,
    input  logic                     load_s2,
    input  logic                     load_s3,
    output logic [7:0]               y,
    output logic [7:0]               u,
    output logic [7:0]               v
);

    localparam int SW = PIXEL_DEPTH + 10;
    localparam logic signed [SW-1:0] RND = $signed({{(SW-1){1'b0}}, 1'b1}) <<< (PIXEL_DEPTH - 1);
    localparam logic signed [SW-1:0] OFFSET = $signed({{(SW-9){1'b0}}, CHROMA_OFFSET});

    function automatic logic signed [SW-1:0] coef(input logic signed [8:0] c);
        return SW'(c);
    endfunction

    // Sign bit forces 0, any set bit above bit 7 saturates to the upper bound.
    function automatic logic [7:0] clamp8(input logic signed [SW-1:0] x);
        logic [7:0] res_s;
        if (x[SW-1]) begin
            res_s = CLAMP_MIN;
        end else if (|x[SW-2:8]) begin
            res_s = CLAMP_MAX;
        end else begin
            res_s = x[7:0];
        end
        return res_s;
    endfunction

    logic [PIXEL_DEPTH-1:0] r_r, g_r, b_r;
    logic signed [SW-1:0]   r_s, g_s, b_s;
    logic signed [SW-1:0]   y_sum_s, u_sum_s, v_sum_s;
    logic signed [SW-1:0]   y_sum_r, u_sum_r, v_sum_r;
    logic [7:0]             y_clamp_s, u_clamp_s, v_clamp_s;
    logic [7:0]             y_r, u_r, v_r;

    // S1: capture the pixel components
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_r <= '0;
            g_r <= '0;
            b_r <= '0;
        end else if (load_s1) begin
            r_r <= rgb[3*PIXEL_DEPTH-1:2*PIXEL_DEPTH];
            g_r <= rgb[2*PIXEL_DEPTH-1:PIXEL_DEPTH];
            b_r <= rgb[PIXEL_DEPTH-1:0];
        end
    end

    // Products and signed sums with rounding constant
    always_comb begin
        r_s     = $signed({10'b0, r_r});
        g_s     = $signed({10'b0, g_r});
        b_s     = $signed({10'b0, b_r});
        y_sum_s = r_s * coef(COEF_Y_R) + g_s * coef(COEF_Y_G) + b_s * coef(COEF_Y_B) + RND;
        u_sum_s = r_s * coef(COEF_U_R) + g_s * coef(COEF_U_G) + b_s * coef(COEF_U_B) + RND;
        v_sum_s = r_s * coef(COEF_V_R) + g_s * coef(COEF_V_G) + b_s * coef(COEF_V_B) + RND;
    end

    // S2: register the sums
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            y_sum_r <= '0;
            u_sum_r <= '0;
            v_sum_r <= '0;
        end else if (load_s2) begin
            y_sum_r <= y_sum_s;
            u_sum_r <= u_sum_s;
            v_sum_r <= v_sum_s;
        end
    end

    // Floor shift back to 8-bit scale, chroma offset, saturate
    always_comb begin
        y_clamp_s = clamp8(y_sum_r >>> PIXEL_DEPTH);
        u_clamp_s = clamp8((u_sum_r >>> PIXEL_DEPTH) + OFFSET);
        v_clamp_s = clamp8((v_sum_r >>> PIXEL_DEPTH) + OFFSET);
    end

    // S3: register clamped components
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            y_r <= '0;
            u_r <= '0;
            v_r <= '0;
        end else if (load_s3) begin
            y_r <= y_clamp_s;
            u_r <= u_clamp_s;
            v_r <= v_clamp_s;
        end
    end

    assign y = y_r;
    assign u = u_r;
    assign v = v_r;

endmodule

// File: rtl/rgb_to_yuv422_pipe.sv
// Fully pipelined multi-pixel RGB -> packed YUV422 converter, fixed 4-cycle latency.
// Mode and chroma-averaging travel with each beat so mid-stream changes never glitch.
module rgb_to_yuv422_pipe
    import csi_yuv_pkg::*;
#(
    parameter int PIXEL_DEPTH   = 12,
    parameter int PIXEL_PER_CLK = 4
)
(
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [PIXEL_DEPTH*PIXEL_PER_CLK*3-1:0] rgb_i,
    input  logic                                   rgb_valid_i,
    input  logic [1:0]                             mode_i,
    input  logic                                   chroma_avg_i,
    output logic [PIXEL_PER_CLK*16-1:0]            yuv_o,
    output logic                                   yuv_valid_o
);

    localparam int NPAIR = PIXEL_PER_CLK / 2;

    generate
        if ((PIXEL_PER_CLK % 2) != 0 || PIXEL_PER_CLK < 2) begin : g_bad_ppc
            $error("rgb_to_yuv422_pipe: PIXEL_PER_CLK must be even and >= 2");
        end
        if (PIXEL_DEPTH < 8 || PIXEL_DEPTH > 16) begin : g_bad_depth
            $error("rgb_to_yuv422_pipe: PIXEL_DEPTH must be within 8..16");
        end
    endgenerate

    logic       v1_r, v2_r, v3_r;
    logic [1:0] mode1_r, mode2_r, mode3_r;
    logic       avg1_r, avg2_r, avg3_r;
    logic [7:0] y_s [PIXEL_PER_CLK];
    logic [7:0] u_s [PIXEL_PER_CLK];
    logic [7:0] v_s [PIXEL_PER_CLK];
    logic [PIXEL_PER_CLK*16-1:0] yuv_next_s;

    // Valid shift chain; bubbles move through unchanged
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v1_r        <= 1'b0;
            v2_r        <= 1'b0;
            v3_r        <= 1'b0;
            yuv_valid_o <= 1'b0;
        end else begin
            v1_r        <= rgb_valid_i;
            v2_r        <= v1_r;
            v3_r        <= v2_r;
            yuv_valid_o <= v3_r;
        end
    end

    // Per-beat side-band controls follow their beat
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mode1_r <= 2'd0;
            mode2_r <= 2'd0;
            mode3_r <= 2'd0;
            avg1_r  <= 1'b0;
            avg2_r  <= 1'b0;
            avg3_r  <= 1'b0;
        end else begin
            if (rgb_valid_i) begin
                mode1_r <= mode_i;
                avg1_r  <= chroma_avg_i;
            end
            if (v1_r) begin
                mode2_r <= mode1_r;
                avg2_r  <= avg1_r;
            end
            if (v2_r) begin
                mode3_r <= mode2_r;
                avg3_r  <= avg2_r;
            end
        end
    end

    for (genvar k = 0; k < PIXEL_PER_CLK; k++) begin : g_pix
        rgb_to_yuv_pixel #(
            .PIXEL_DEPTH (PIXEL_DEPTH)
        ) u_pix (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .rgb     (rgb_i[(PIXEL_PER_CLK-1-k)*3*PIXEL_DEPTH +: 3*PIXEL_DEPTH]),
            .load_s1 (rgb_valid_i),
            .load_s2 (v1_r),
            .load_s3 (v2_r),
            .y       (y_s[k]),
            .u       (u_s[k]),
            .v       (v_s[k])
        );
    end

    // Pair chroma selection and byte-order packing; pair 0 lands at the MSB end
    always_comb begin
        logic [7:0] u_pair_s;
        logic [7:0] v_pair_s;
        yuv_next_s = '0;
        u_pair_s   = 8'd0;
        v_pair_s   = 8'd0;
        for (int p = 0; p < NPAIR; p++) begin
            u_pair_s = avg3_r ? chroma_avg(u_s[2*p], u_s[2*p+1]) : u_s[2*p];
            v_pair_s = avg3_r ? chroma_avg(v_s[2*p], v_s[2*p+1]) : v_s[2*p];
            yuv_next_s[(NPAIR-1-p)*32 +: 32] =
                pack_pair(mode3_r, y_s[2*p], y_s[2*p+1], u_pair_s, v_pair_s);
        end
    end

    // S4: output word holds its last valid value during bubbles
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            yuv_o <= '0;
        end else if (v3_r) begin
            yuv_o <= yuv_next_s;
        end
    end

endmodule

// File: doc/rgb_to_yuv422_pipe.md
Name: rgb_to_yuv422_pipe

Overview:
- Parametrised, fully pipelined RGB to YUV422 converter for the debayer → output path of the MIPI CSI RX bridge.
- Accepts PIXEL_PER_CLK RGB pixels per beat at PIXEL_DEPTH bits per colour and emits packed 8-bit YUV422.
- Selectable byte order (YUYV/UYVY/YVYU/VYUY) and optional chroma averaging across each pixel pair.
- Clamps results to 0..255.
- Runs on the rising edge with a fixed 4-cycle latency.

Parameters:
- PIXEL_DEPTH, 12, bits per colour component; legal range 8..16.
- PIXEL_PER_CLK, 4, pixels per beat; must be even and ≥2.

Ports:
- clk_i  input  1  pixel clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- rgb_i  input  PIXEL_DEPTH*PIXEL_PER_CLK*3  pixel k at rgb_i[(PIXEL_PER_CLK-1-k)*3*PIXEL_DEPTH +: 3*PIXEL_DEPTH]; pixel 0 is the MSB end; within a pixel {R,G,B}, with R at the MSB.
- rgb_valid_i  input  1  rgb_i is valid this cycle.
- mode_i  input  2  byte order: 0=YUYV, 1=UYVY, 2=YVYU, 3=VYUY.
- chroma_avg_i  input  1  1: pair chroma = rounded average of both pixels; 0: chroma taken from the even pixel.
- yuv_o  output  PIXEL_PER_CLK*16  pair p (pixels 2p, 2p+1) in yuv_o[(PIXEL_PER_CLK/2-1-p)*32 +: 32]; pair 0 is the MSB end.
- yuv_valid_o  output  1  yuv_o is valid.

Behaviour:
- Reset:
  - yuv_o=0 and yuv_valid_o=0; all stage valid bits and data registers are 0.
  - Assertion takes effect immediately (asynchronous), including mid-stream.
  - Beats in flight are discarded and never emerge.
  - After deassertion, the first input beat appears at the output 4 cycles later.
- Pipeline:
  - Fixed latency of 4 rising edges from rgb_valid_i to yuv_valid_o; no backpressure.
  - S1: register rgb_i, mode_i and chroma_avg_i; form the 9 products per pixel.
  - S2: signed sums plus rounding constant.
  - S3: arithmetic shift, +128 offset on chroma, clamp.
  - S4: chroma select/average and byte packing into yuv_o.
- Valid handling:
  - Each stage carries a valid bit.
  - A stage's data registers load only when its incoming valid is 1; otherwise they hold.
  - yuv_o therefore holds the last valid word while yuv_valid_o=0.
  - Bubbles propagate unchanged; back-to-back beats are sustained at 1 beat/cycle.
- Arithmetic per pixel, with SH=PIXEL_DEPTH and RND=2^(PIXEL_DEPTH-1):
  - Y = clamp((77R+150G+29B+RND) >>> SH)
  - U = clamp(((-43R-84G+127B+RND) >>> SH) + 128)
  - V = clamp(((127R-106G-21B+RND) >>> SH) + 128)
  - Sums are signed, PIXEL_DEPTH+10 bits; >>> is an arithmetic shift (floor toward -inf).
  - clamp() saturates to 0..255 (for example, Y of full white is 256 before clamping → 255).
- Chroma per pair:
  - chroma_avg_i=1: U=(U_even+U_odd+1)>>1 and V likewise, 9-bit intermediate.
  - chroma_avg_i=0: U=U_even, V=V_even; the odd pixel's chroma is unused.
- Packing per 32-bit pair word, MSB first:
  - mode 0: {Y0,U,Y1,V}
  - mode 1: {U,Y0,V,Y1}
  - mode 2: {Y0,V,Y1,U}
  - mode 3: {V,Y0,U,Y1}
- Mode changes:
  - mode_i and chroma_avg_i are sampled with each beat and travel with it.
  - A change mid-stream affects only beats accepted after the change; there is no glitch or reordering of earlier beats.
- No inter-beat state: pairs never span beats, so odd PIXEL_PER_CLK is illegal (elaboration error).

Decomposition:
- Package csi_yuv_pkg holds:
  - the 9 coefficients as signed constants;
  - mode encodings YUV_MODE_YUYV/UYVY/YVYU/VYUY;
  - the chroma offset 128 and the clamp bounds.
- Sub-module rgb_to_yuv_pixel implements S1–S3 for one pixel, parametrised by PIXEL_DEPTH. The top instantiates it PIXEL_PER_CLK times and owns the valid/mode pipeline and S4 packing.

Test Plan:
- All 4 pixels white (4095), mode 0, avg 0, valid 1 beat → 4 cycles later yuv_valid_o=1 and each pair word = {FF,80,FF,80}; for the next beat yuv_valid_o=0 and yuv_o holds its value.
- All pixels black, then a pixel pair of red (R=4095) and blue (B=4095), avg 0, mode 0 →
  - black pair word = {00,80,00,80};
  - red/blue pair word = {4D,55,1D,FF} (Y0=77, U=85, Y1=29, V=255).
- Same red/blue pair with avg 1 → {4D,AA,1D,B5} (U=170, V=181); mode 1 with avg 1 → {AA,4D,B5,1D}.
- 8 consecutive beats with valid pattern 1,1,0,1,0,0,1,1 and mode_i changed 0→3 at beat 4 → yuv_valid_o shows the same pattern delayed by 4 cycles; only beats 4..8 are packed VYUY.
- Assert reset_i for 1 cycle while 3 beats are in flight → yuv_valid_o=0 and yuv_o=0 immediately; none of the 3 beats ever appears; a new beat after reset emerges 4 cycles later.
- Regression with PIXEL_DEPTH=10 and PIXEL_PER_CLK=2: 1023 white → {FF,80,FF,80}; red 1023 → Y=77, V=255.
